load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit_extend.sv | 28 ++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-serial load/store unit.
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        XFER   = 2'b01,
        FINISH = 2'b10,
        DONE   = 2'b11
    } state_e;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] last_index(input size_e sz);
        case (sz)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Combinational sign/zero extension of an assembled little-endian load result.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  size_e                 size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~unsigned_i & word_i[BYTE_W-1];
    assign fill_h = ~unsigned_i & word_i[2*BYTE_W-1];

    always_comb begin
        word_o = word_i;
        case (size_i)
            SZ_BYTE: word_o = {{(DATA_WIDTH-BYTE_W){fill_b}}, word_i[BYTE_W-1:0]};
            SZ_HALF: word_o = {{(DATA_WIDTH-2*BYTE_W){fill_h}}, word_i[2*BYTE_W-1:0]};
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit bridging a CPU-width port to a byte-wide memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [1:0]               size_i,
    input  logic                     unsigned_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     misaligned_o,
    output logic                     mem_wr_en_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [BYTE_W-1:0]        mem_wdata_o,
    input  logic [BYTE_W-1:0]        mem_rdata_i
);

    state_e                   state_q, state_d;
    logic [1:0]               k_q, k_d;
    logic [1:0]               last_q, last_d;
    logic                     we_q, we_d;
    logic                     uns_q, uns_d;
    size_e                    size_q, size_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    buf_q, buf_d;
    logic                     cap_q, cap_d;
    logic [1:0]               cap_lane_q, cap_lane_d;
    logic [1:0]               k_next;
    logic [DATA_WIDTH-1:0]    ext_word;
    size_e                    req_size;
    logic                     req_misaligned;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                     mis_q, mis_d;
`endif

    assign req_size = decode_size(size_i);
    assign k_next   = k_q + 2'd1;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = ((req_size == SZ_HALF) && addr_i[0]) ||
                            ((req_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    lsu_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_extend (
        .word_i    (buf_d),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .word_o    (ext_word)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        buf_d       = buf_q;
        cap_d       = 1'b0;
        cap_lane_d  = k_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d       = mis_q;
`endif

        // A load byte arrives one cycle after its address; drop it into its lane.
        if (cap_q) begin
            buf_d[{cap_lane_q, 3'b000} +: BYTE_W] = mem_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    uns_d   = unsigned_i;
                    size_d  = req_size;
                    last_d  = last_index(req_size);
                    wdata_d = wdata_i;
                    k_d     = 2'd0;
                    buf_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d   = req_misaligned;
`endif
                    if (req_misaligned) begin
                        state_d = DONE;
                    end else begin
                        mem_addr_d  = addr_i;
                        mem_wdata_d = wdata_i[BYTE_W-1:0];
                        state_d     = XFER;
                    end
                end
            end
            XFER: begin
                cap_d      = ~we_q;
                cap_lane_d = k_q;
                if (k_q == last_q) begin
                    state_d = we_q ? DONE : FINISH;
                end else begin
                    k_d         = k_next;
                    mem_addr_d  = mem_addr_q + ADDRESS_WIDTH'(1);
                    mem_wdata_d = wdata_q[{k_next, 3'b000} +: BYTE_W];
                end
            end
            FINISH: begin
                rdata_d = ext_word;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k_q         <= '0;
            last_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            buf_q       <= '0;
            cap_q       <= 1'b0;
            cap_lane_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            buf_q       <= buf_d;
            cap_q       <= cap_d;
            cap_lane_q  <= cap_lane_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    // Gating with rst_i keeps the byte in flight at the reset edge from being written.
    assign mem_wr_en_o = (state_q == XFER) && we_q && !rst_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_o = done_o && mis_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule
